// File: rtl/word_dma_if.sv
// Bus bundle for word_dma: Avalon-MM register slave plus Avalon-MM SDRAM master.
// Modport "master" is the DMA engine's view; "slave" is the CPU/SDRAM side.
interface word_dma_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [3:0]        slave_address;
    logic              slave_read;
    logic [31:0]       slave_readdata;
    logic              slave_write;
    logic [31:0]       slave_writedata;
    logic              slave_waitrequest;
    logic              master_waitrequest;
    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;

    modport master (
        input  slave_address, slave_read, slave_write, slave_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output slave_readdata, slave_waitrequest,
        output master_address, master_read, master_write, master_writedata
    );

    modport slave (
        output slave_address, slave_read, slave_write, slave_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  slave_readdata, slave_waitrequest,
        input  master_address, master_read, master_write, master_writedata
    );
endinterface

// File: rtl/word_dma.sv
// word_dma: CPU-programmed engine that copies or fills SDRAM word regions,
// with pipelined reads buffered in an in-order FIFO and a level done IRQ.
module word_dma #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    word_dma_if.master bus,
    output logic       irq
);
    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                OCC_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);
    localparam logic [OCC_W:0]    DEPTH_C = (OCC_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

    state_e            state_q, state_d;
    logic              irq_en_q, irq_en_d, fill_mode_q, fill_mode_d;
    logic              src_fixed_q, src_fixed_d, dst_fixed_q, dst_fixed_d;
    logic [ADDR_W-1:0] dst_q, dst_d, src_q, src_d;
    logic [CNT_W-1:0]  count_q, count_d, rd_left_q, rd_left_d, wr_left_q, wr_left_d;
    logic [DATA_W-1:0] fill_word_q, fill_word_d;
    logic              done_q, done_d;
    logic [OCC_W-1:0]  outst_q, outst_d, fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic              m_read_q, m_read_d, m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic             busy, cfg_we, cmd_pending, rd_acc, wr_acc, cmd_free, push, pop;
    logic [OCC_W:0]   credit;

    assign busy        = (state_q != S_IDLE);
    assign cfg_we      = bus.slave_write & ~busy;
    assign cmd_pending = m_read_q | m_write_q;
    assign rd_acc      = m_read_q & ~bus.master_waitrequest;
    assign wr_acc      = m_write_q & ~bus.master_waitrequest;
    assign cmd_free    = ~cmd_pending | rd_acc | wr_acc;
    // Data with nothing outstanding is a leftover from an aborted run and is dropped.
    assign push        = bus.master_readdatavalid & (outst_q != '0);

    always_comb begin
        // NOTE: every next-state signal starts from its hold value, so no branch can infer a latch.
        state_d     = state_q;
        irq_en_d    = irq_en_q;
        fill_mode_d = fill_mode_q;
        src_fixed_d = src_fixed_q;
        dst_fixed_d = dst_fixed_q;
        dst_d       = dst_q;
        src_d       = src_q;
        count_d     = count_q;
        fill_word_d = fill_word_q;
        done_d      = done_q;
        rd_left_d   = rd_left_q;
        wr_left_d   = wr_left_q;
        outst_d     = outst_q;
        m_read_d    = m_read_q;
        m_write_d   = m_write_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        pop         = 1'b0;
        credit      = '0;

        if (cfg_we) begin
            case (bus.slave_address)
                4'd0: begin
                    {dst_fixed_d, src_fixed_d, fill_mode_d, irq_en_d} = bus.slave_writedata[4:1];
                    if (bus.slave_writedata[0]) begin
                        state_d   = S_RUN;
                        done_d    = 1'b0;
                        rd_left_d = count_q;
                        wr_left_d = count_q;
                    end
                end
                4'd1:    dst_d       = ADDR_W'(bus.slave_writedata);
                4'd2:    src_d       = ADDR_W'(bus.slave_writedata);
                4'd3:    count_d     = CNT_W'(bus.slave_writedata);
                4'd4:    fill_word_d = DATA_W'(bus.slave_writedata);
                default: ;
            endcase
        end
        if (bus.slave_write && bus.slave_address == 4'd5 && bus.slave_writedata[1]) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                if (rd_acc) begin
                    rd_left_d = rd_left_q - 1'b1;
                    if (!src_fixed_q) src_d = src_q + STEP;
                end
                if (wr_acc) begin
                    wr_left_d = wr_left_q - 1'b1;
                    if (!dst_fixed_q) dst_d = dst_q + STEP;
                end
                outst_d = outst_q + OCC_W'(rd_acc) - OCC_W'(push);
                if (cmd_free) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    // Reads in flight plus buffered words must never exceed the FIFO.
                    credit = {1'b0, outst_d} + {1'b0, fifo_cnt_q} + (OCC_W + 1)'(push);
                    if (!fill_mode_q && fifo_cnt_q != '0) begin
                        m_write_d = 1'b1;
                        m_addr_d  = dst_d;
                        m_wdata_d = fifo_mem[rp_q];
                        pop       = 1'b1;
                    end else if (fill_mode_q && wr_left_d != '0) begin
                        m_write_d = 1'b1;
                        m_addr_d  = dst_d;
                        m_wdata_d = fill_word_q;
                    end else if (!fill_mode_q && rd_left_d != '0 && credit < DEPTH_C) begin
                        m_read_d  = 1'b1;
                        m_addr_d  = src_d;
                    end
                end
                if (wr_left_q == '0 && !cmd_pending && outst_q == '0) state_d = S_FINISH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase
    end

    assign fifo_cnt_d = fifo_cnt_q + OCC_W'(push) - OCC_W'(pop);
    assign wp_d       = wp_q + PTR_W'(push);
    assign rp_d       = rp_q + PTR_W'(pop);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            irq_en_q    <= 1'b0;
            fill_mode_q <= 1'b0;
            src_fixed_q <= 1'b0;
            dst_fixed_q <= 1'b0;
            dst_q       <= '0;
            src_q       <= '0;
            count_q     <= '0;
            fill_word_q <= '0;
            done_q      <= 1'b0;
            rd_left_q   <= '0;
            wr_left_q   <= '0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            irq_en_q    <= irq_en_d;
            fill_mode_q <= fill_mode_d;
            src_fixed_q <= src_fixed_d;
            dst_fixed_q <= dst_fixed_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            count_q     <= count_d;
            fill_word_q <= fill_word_d;
            done_q      <= done_d;
            rd_left_q   <= rd_left_d;
            wr_left_q   <= wr_left_d;
            outst_q     <= outst_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

    // NOTE: FIFO storage is not reset; the reset occupancy counters make stale words invisible.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wp_q] <= bus.master_readdata;
    end

    always_comb begin
        bus.slave_readdata = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                4'd0:    bus.slave_readdata = {27'd0, dst_fixed_q, src_fixed_q, fill_mode_q, irq_en_q, 1'b0};
                4'd1:    bus.slave_readdata = 32'(dst_q);
                4'd2:    bus.slave_readdata = 32'(src_q);
                4'd3:    bus.slave_readdata = 32'(count_q);
                4'd4:    bus.slave_readdata = 32'(fill_word_q);
                4'd5:    bus.slave_readdata = {30'd0, done_q, busy};
                4'd6:    bus.slave_readdata = 32'(wr_left_q);
                default: bus.slave_readdata = '0;
            endcase
        end
    end

    assign bus.slave_waitrequest = 1'b0;
    assign bus.master_read       = m_read_q;
    assign bus.master_write      = m_write_q;
    assign bus.master_address    = m_addr_q;
    assign bus.master_writedata  = m_wdata_q;
    assign irq                   = done_q & irq_en_q;
endmodule
